// File: rtl/spi_bus_arbiter.sv
// spi_bus_arbiter
// Transaction-level front end for the SPI byte engine. Two requesters
// (0 = IMU poller, 1 = configuration master) are arbitrated round-robin. A
// granted transaction is sequenced as START, address byte, 0..MAX_BYTES data
// bytes, STOP, then an SS-high guard gap. Read bytes are returned packed.
//
// Ports
//   clk, rst           single clock, synchronous active-high reset
//   req_valid/ready    per-requester request handshake (ready is one-hot)
//   req_rw             1 = read, 0 = write, one bit per requester
//   req_addr           7-bit register address per requester ([6:0] = req0)
//   req_len            4-bit data byte count per requester ([3:0] = req0)
//   req_wdata          MAX_BYTES write bytes per requester, byte k at [8k+7:8k]
//   resp_valid         one-cycle completion pulse to the owning requester
//   resp_rdata         read bytes of the last transaction (shared)
//   busy               high from accept through the end of the guard gap
//   eng_cmd_*          command to byte engine: 0 = START, 1 = STOP, 2 = XFER
//   eng_done/rx_byte   completion pulse and MISO byte from the engine
module spi_bus_arbiter #(
   parameter int MAX_BYTES    = 6,
   parameter int GUARD_CYCLES = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [1:0]               req_valid,
   output logic [1:0]               req_ready,
   input  logic [1:0]               req_rw,
   input  logic [13:0]              req_addr,
   input  logic [7:0]               req_len,
   input  logic [2*8*MAX_BYTES-1:0] req_wdata,
   output logic [1:0]               resp_valid,
   output logic [8*MAX_BYTES-1:0]   resp_rdata,
   output logic                     busy,
   output logic                     eng_cmd_valid,
   input  logic                     eng_cmd_ready,
   output logic [1:0]               eng_cmd,
   output logic [7:0]               eng_tx_byte,
   input  logic                     eng_done,
   input  logic [7:0]               eng_rx_byte
);
   localparam int         IW         = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
   localparam int         WB         = 8 * MAX_BYTES;
   localparam logic [3:0] MAX_LEN    = 4'(MAX_BYTES);
   localparam logic [3:0] GUARD_LOAD = 4'(GUARD_CYCLES - 1);
   localparam logic [1:0] CMD_START  = 2'd0;
   localparam logic [1:0] CMD_STOP   = 2'd1;
   localparam logic [1:0] CMD_XFER   = 2'd2;

   typedef enum logic [2:0] {S_IDLE, S_START, S_ADDR, S_DATA, S_STOP, S_GUARD} state_t;
   state_t state, state_nxt;

   logic                      issued;    // command accepted, waiting for eng_done
   logic                      owner;     // requester being served
   logic                      last_gnt;  // requester granted most recently
   logic                      rw;
   logic [6:0]                addr;
   logic [3:0]                remain;    // data bytes still to transfer
   logic [IW-1:0]             idx;       // current data byte index
   logic [MAX_BYTES-1:0][7:0] wdata;
   logic [MAX_BYTES-1:0][7:0] rdata;
   logic [3:0]                guard_cnt;

   logic                      gnt, accept, cmd_done;
   logic [6:0]                sel_addr;
   logic [3:0]                sel_len;
   logic [WB-1:0]             sel_wdata;

   // Arbitration: with both valid, the requester not granted last wins.
   always_comb begin
      gnt       = (req_valid == 2'b11) ? ~last_gnt : req_valid[1];
      accept    = (state == S_IDLE) && (guard_cnt == 4'd0) && (|req_valid);
      req_ready = '0;
      if (accept) req_ready[gnt] = 1'b1;
      sel_addr  = gnt ? req_addr[13:7]         : req_addr[6:0];
      sel_len   = gnt ? req_len[7:4]           : req_len[3:0];
      sel_wdata = gnt ? req_wdata[2*WB-1:WB]   : req_wdata[WB-1:0];
   end

   // eng_done only counts while a command is outstanding.
   assign cmd_done   = issued && eng_done &&
                       (state inside {S_START, S_ADDR, S_DATA, S_STOP});
   assign busy       = (state != S_IDLE);
   assign resp_rdata = rdata;

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Next state and engine command outputs. Valid is held until the engine
   // takes the command, then dropped until eng_done.
   always_comb begin
      state_nxt     = state;
      eng_cmd_valid = 1'b0;
      eng_cmd       = CMD_START;
      eng_tx_byte   = 8'h00;
      case (state)
         S_IDLE:  if (accept) state_nxt = S_START;
         S_START: begin
            eng_cmd_valid = ~issued;
            eng_cmd       = CMD_START;
            if (cmd_done) state_nxt = S_ADDR;
         end
         S_ADDR: begin
            eng_cmd_valid = ~issued;
            eng_cmd       = CMD_XFER;
            eng_tx_byte   = {rw, addr};
            if (cmd_done) state_nxt = (remain == 4'd0) ? S_STOP : S_DATA;
         end
         S_DATA: begin
            eng_cmd_valid = ~issued;
            eng_cmd       = CMD_XFER;
            eng_tx_byte   = rw ? 8'h00 : wdata[idx];
            if (cmd_done && remain == 4'd1) state_nxt = S_STOP;
         end
         S_STOP: begin
            eng_cmd_valid = ~issued;
            eng_cmd       = CMD_STOP;
            if (cmd_done) state_nxt = S_GUARD;
         end
         S_GUARD: if (guard_cnt == 4'd0) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         issued     <= 1'b0;
         owner      <= 1'b0;
         last_gnt   <= 1'b1;   // makes requester 0 the preferred one
         rw         <= 1'b0;
         addr       <= '0;
         remain     <= '0;
         idx        <= '0;
         wdata      <= '0;
         rdata      <= '0;
         guard_cnt  <= '0;
         resp_valid <= '0;
      end else begin
         resp_valid <= '0;
         if (accept) begin
            owner    <= gnt;
            last_gnt <= gnt;
            rw       <= req_rw[gnt];
            addr     <= sel_addr;
            remain   <= (sel_len > MAX_LEN) ? MAX_LEN : sel_len;
            idx      <= '0;
            wdata    <= sel_wdata;
            rdata    <= '0;
         end
         if (eng_cmd_valid && eng_cmd_ready) issued <= 1'b1;
         if (cmd_done) begin
            issued <= 1'b0;
            if (state == S_DATA) begin
               if (rw) rdata[idx] <= eng_rx_byte;
               idx    <= idx + 1'b1;
               remain <= remain - 1'b1;
            end
            if (state == S_STOP) begin
               resp_valid[owner] <= 1'b1;
               guard_cnt         <= GUARD_LOAD;
            end
         end else if (state == S_GUARD && guard_cnt != 4'd0) begin
            guard_cnt <= guard_cnt - 1'b1;
         end
      end
   end
endmodule

// File: doc/spi_bus_arbiter.md
Name: spi_bus_arbiter

Overview:
- Transaction-level controller in front of the SPI byte engine (`spi_driver` generation), which executes one START, STOP or 8-bit XFER command at a time.
- Arbitrates two requesters (IMU poller, configuration master) round-robin.
- Sequences each granted transaction as: START, address byte, 0..MAX_BYTES data bytes, STOP, then an SS-high guard gap.
- Returns read data to the requester as one packed word.

Parameters:
- MAX_BYTES, 6: maximum data bytes per transaction (accel XYZ burst).
- GUARD_CYCLES, 4: minimum clk cycles in IDLE after a STOP completes before the next START may be issued (range 1..15).

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  2  per-requester transaction request; bit i = requester i.
- req_ready  out  2  one-hot; bit i high in the accept cycle (valid&ready = accepted).
- req_rw  in  2  1 = read, 0 = write, per requester.
- req_addr  in  14  7-bit register address per requester, [6:0] = req0.
- req_len  in  8  4-bit data byte count per requester, [3:0] = req0.
- req_wdata  in  2*8*MAX_BYTES  write bytes per requester; byte k at [8k+7:8k] of that requester's slice.
- resp_valid  out  2  one-cycle completion pulse to the owning requester.
- resp_rdata  out  8*MAX_BYTES  read bytes of the completed transaction, shared by both requesters.
- busy  out  1  high from accept through end of guard gap.
- eng_cmd_valid  out  1  command to byte engine.
- eng_cmd_ready  in  1  engine accepts command.
- eng_cmd  out  2  0 = START, 1 = STOP, 2 = XFER.
- eng_tx_byte  out  8  MOSI byte for XFER.
- eng_done  in  1  one-cycle pulse when the accepted command finishes.
- eng_rx_byte  in  8  MISO byte; valid with eng_done after XFER.

Behaviour:
- Reset values: all outputs 0, FSM IDLE, guard counter 0, rr pointer = requester 0 preferred.
- FSM states: IDLE, START, ADDR, DATA, STOP, GUARD.
- IDLE accept:
  - Acceptance is allowed when the guard counter is 0 and any req_valid is high.
  - Arbitration is combinational: single requester wins; if both are valid, the one not granted last wins.
  - req_ready[g] is high that same cycle. At the edge, capture rw, addr, len and wdata, and store g.
  - Next cycle the FSM is in START.
- Length rule: effective len = min(req_len, MAX_BYTES). len = 0 gives an address-only transaction (START, ADDR, STOP).
- Command states (START/ADDR/DATA/STOP):
  - Drive eng_cmd_valid = 1 with eng_cmd/eng_tx_byte held stable until eng_cmd_ready.
  - Then drop valid and wait for eng_done.
  - Only one command is ever outstanding.
- ADDR: eng_tx_byte = {rw, addr[6:0]}; read sets bit 7.
- DATA (byte index k = 0..len-1):
  - Write: tx = wdata[8k+7:8k].
  - Read: tx = 8'h00; on eng_done, store eng_rx_byte into rdata byte k.
  - Advance k on eng_done; after the last byte go to STOP.
  - Bytes of rdata with index >= len are 0; the rdata buffer is cleared at accept.
- STOP done:
  - resp_valid[g] pulses for 1 cycle.
  - resp_rdata is valid in that cycle and holds until the next accept.
  - Write transactions return rdata = 0.
- GUARD:
  - Counter loads GUARD_CYCLES-1 and decrements each cycle.
  - Return to IDLE at 0; acceptance is possible in the following cycle.
  - busy = 0 only in IDLE.
- Requests asserted during busy are held off (req_ready = 0). Requesters keep valid and fields stable until ready.
- eng_done outside a wait state is ignored.
- rst mid-transaction:
  - Immediate return to IDLE, eng_cmd_valid drops, no resp_valid.
  - The byte engine shares rst and deasserts SS.
- Round-robin pointer updates only on accept, not on reset-free idle cycles.

Test Plan:
- Write, req0: req0 write, addr 0x1B, len 1, wdata 0x18.
  - eng_cmd sequence START, XFER 0x1B, XFER 0x18, STOP.
  - resp_valid[0] 1 cycle after STOP eng_done; busy low GUARD_CYCLES cycles later.
- Burst read, req1: req1 read, addr 0x3B, len 6; engine returns 0x01..0x06.
  - Address byte 0xBB; six XFER commands with tx 0x00.
  - resp_rdata = 0x060504030201; resp_valid[1] pulse.
- Round-robin: both valid continuously from reset.
  - Grants are req0, req1, req0, req1.
  - Each START is separated from the previous STOP done by ≥ GUARD_CYCLES cycles.
- Engine backpressure: eng_cmd_ready held 0 for 10 cycles on the ADDR command.
  - eng_cmd_valid, eng_cmd and eng_tx_byte stay constant throughout.
  - Exactly one command is issued.
- Length edges:
  - len 0 → START, ADDR, STOP only.
  - Read with len 9 → clamped to 6 XFER data bytes.
  - Read with len 2 → rdata upper 4 bytes are 0.
- Reset mid-read: rst asserted during the third DATA byte.
  - Next cycle: all outputs 0, no resp_valid.
  - A subsequent req1-only request is accepted immediately and completes normally.
